// File: rtl/transformed_vertex_buffer_if.sv
// rtl/transformed_vertex_buffer_if.sv - vertex write / fetch / clear bundle between transform, assembler and buffer
interface transformed_vertex_buffer_if #(
    parameter int DATAWIDTH        = 12,
    parameter int MAX_VERTEX_COUNT = 16384
);
    localparam int AW = $clog2(MAX_VERTEX_COUNT);

    logic                   i_clear;
    logic                   i_write_en;
    logic [AW-1:0]          i_write_addr;
    logic [3*DATAWIDTH-1:0] i_write_data;
    logic                   i_write_invalid;
    logic                   o_write_ready;
    logic                   i_read_en;
    logic [3*AW-1:0]        i_vertex_addr;
    logic                   o_ready;
    logic [3*DATAWIDTH-1:0] o_v0;
    logic [3*DATAWIDTH-1:0] o_v1;
    logic [3*DATAWIDTH-1:0] o_v2;
    logic                   o_v0_invalid;
    logic                   o_v1_invalid;
    logic                   o_v2_invalid;
    logic                   o_dv;
    logic                   o_clear_done;

    modport slave (
        input  i_clear, i_write_en, i_write_addr, i_write_data, i_write_invalid,
        input  i_read_en, i_vertex_addr,
        output o_write_ready, o_ready, o_v0, o_v1, o_v2,
        output o_v0_invalid, o_v1_invalid, o_v2_invalid, o_dv, o_clear_done
    );

    modport master (
        output i_clear, i_write_en, i_write_addr, i_write_data, i_write_invalid,
        output i_read_en, i_vertex_addr,
        input  o_write_ready, o_ready, o_v0, o_v1, o_v2,
        input  o_v0_invalid, o_v1_invalid, o_v2_invalid, o_dv, o_clear_done
    );
endinterface

// File: rtl/transformed_vertex_buffer.sv
// rtl/transformed_vertex_buffer.sv - single-port vertex store serving three-vertex fetches, writes and clear sweeps
module transformed_vertex_buffer #(
    parameter int DATAWIDTH        = 12,
    parameter int MAX_VERTEX_COUNT = 16384
) (
    input  logic                      clk,
    input  logic                      rstn,
    transformed_vertex_buffer_if.slave bus
);
    localparam int AW = $clog2(MAX_VERTEX_COUNT);
    localparam int VW = 3 * DATAWIDTH;
    localparam int WW = VW + 1;
    localparam logic [AW:0] CLR_LAST = (AW + 1)'(MAX_VERTEX_COUNT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD0    = 3'd1;
    localparam logic [2:0] S_RD1    = 3'd2;
    localparam logic [2:0] S_RD2    = 3'd3;
    localparam logic [2:0] S_RDWAIT = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;

    logic [2:0]    state;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [AW:0]   clr_cnt;

    logic [WW-1:0] mem [MAX_VERTEX_COUNT];
    logic [WW-1:0] rd_q;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [WW-1:0] ram_wdata;

    assign bus.o_ready       = (state == S_IDLE);
    assign bus.o_write_ready = (state == S_IDLE) & ~bus.i_read_en & ~bus.i_clear;

    // The single RAM port is steered by state; IDLE lends it to the vertex writer.
    always_comb begin
        ram_addr  = bus.i_write_addr;
        ram_we    = 1'b0;
        ram_wdata = {bus.i_write_invalid, bus.i_write_data};
        case (state)
            S_IDLE:  ram_we = bus.o_write_ready & bus.i_write_en;
            S_RD0:   ram_addr = addr0;
            S_RD1:   ram_addr = addr1;
            S_RD2:   ram_addr = addr2;
            S_CLEAR: begin
                ram_addr  = clr_cnt[AW-1:0];
                ram_we    = 1'b1;
                ram_wdata = {1'b1, {VW{1'b0}}};
            end
            default: ram_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= S_IDLE;
            addr0            <= '0;
            addr1            <= '0;
            addr2            <= '0;
            clr_cnt          <= '0;
            bus.o_v0         <= '0;
            bus.o_v1         <= '0;
            bus.o_v2         <= '0;
            bus.o_v0_invalid <= 1'b0;
            bus.o_v1_invalid <= 1'b0;
            bus.o_v2_invalid <= 1'b0;
            bus.o_dv         <= 1'b0;
            bus.o_clear_done <= 1'b0;
        end else begin
            bus.o_dv         <= 1'b0;
            bus.o_clear_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_clear) begin
                        clr_cnt <= '0;
                        state   <= S_CLEAR;
                    end else if (bus.i_read_en) begin
                        addr0 <= bus.i_vertex_addr[AW-1:0];
                        addr1 <= bus.i_vertex_addr[2*AW-1:AW];
                        addr2 <= bus.i_vertex_addr[3*AW-1:2*AW];
                        state <= S_RD0;
                    end
                end
                S_RD0: state <= S_RD1;
                // Each read state captures the word addressed one state earlier.
                S_RD1: begin
                    {bus.o_v0_invalid, bus.o_v0} <= rd_q;
                    state <= S_RD2;
                end
                S_RD2: begin
                    {bus.o_v1_invalid, bus.o_v1} <= rd_q;
                    state <= S_RDWAIT;
                end
                S_RDWAIT: begin
                    {bus.o_v2_invalid, bus.o_v2} <= rd_q;
                    bus.o_dv <= 1'b1;
                    state    <= S_IDLE;
                end
                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        bus.o_clear_done <= 1'b1;
                        state            <= S_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_transformed_vertex_buffer.sv
// tb/tb_transformed_vertex_buffer.sv - directed vector bench for transformed_vertex_buffer
module tb_transformed_vertex_buffer;
    localparam int DW   = 12;
    localparam int MAXV = 8;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    transformed_vertex_buffer_if #(.DATAWIDTH(DW), .MAX_VERTEX_COUNT(MAXV)) vif ();

    transformed_vertex_buffer #(.DATAWIDTH(DW), .MAX_VERTEX_COUNT(MAXV)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          a0, a1, a2;
        logic [36:0] e0, e1, e2;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [36:0] mk(input int x, input int y, input int z, input bit inv);
        logic [11:0] xs, ys, zs;
        xs = x[11:0];
        ys = y[11:0];
        zs = z[11:0];
        return {inv, zs, ys, xs};
    endfunction

    task automatic wr(input int a, input logic [36:0] w);
        int n;
        n = 0;
        @(negedge clk);
        vif.i_write_en      = 1'b1;
        vif.i_write_addr    = a[2:0];
        vif.i_write_data    = w[35:0];
        vif.i_write_invalid = w[36];
        #1;
        while (!vif.o_write_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("wr_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 vif.i_write_en = 1'b0;
    endtask

    // Request at edge N; cycle k lies between edges N+k and N+k+1.
    task automatic do_read(input int a0, input int a1, input int a2, input int inj_k,
                           output int dv_cnt, output int dv_k,
                           output logic [36:0] r0, output logic [36:0] r1, output logic [36:0] r2);
        dv_cnt = 0;
        dv_k   = -1;
        r0 = '0; r1 = '0; r2 = '0;
        @(negedge clk);
        vif.i_read_en     = 1'b1;
        vif.i_vertex_addr = {a2[2:0], a1[2:0], a0[2:0]};
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (vif.o_dv) begin
                dv_cnt++;
                dv_k = k;
                r0 = {vif.o_v0_invalid, vif.o_v0};
                r1 = {vif.o_v1_invalid, vif.o_v1};
                r2 = {vif.o_v2_invalid, vif.o_v2};
            end
            if (k == inj_k) begin
                vif.i_read_en     = 1'b1;
                vif.i_vertex_addr = 9'h1ff;
            end else begin
                vif.i_read_en = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input int i);
        int dv_cnt, dv_k;
        logic [36:0] r0, r1, r2;
        do_read(vecs[i].a0, vecs[i].a1, vecs[i].a2, -1, dv_cnt, dv_k, r0, r1, r2);
        chk($sformatf("vec%0d_dv_count", i), 64'(dv_cnt), 64'd1);
        chk($sformatf("vec%0d_dv_latency", i), 64'(dv_k), 64'd4);
        chk($sformatf("vec%0d_v0", i), 64'(r0), 64'(vecs[i].e0));
        chk($sformatf("vec%0d_v1", i), 64'(r1), 64'(vecs[i].e1));
        chk($sformatf("vec%0d_v2", i), 64'(r2), 64'(vecs[i].e2));
    endtask

    initial begin
        logic [36:0] v5, v6, v7, z, va, vb, vn, r0, r1, r2;
        int dv_cnt, dv_k, wr_k, bad, low_cnt, done_cnt, done_k;

        checks = 0;
        errors = 0;
        v5 = mk(10, -20, 30, 1'b0);
        v6 = mk(-1, 2, -3, 1'b1);
        v7 = mk(100, 0, -100, 1'b0);
        z  = mk(0, 0, 0, 1'b1);
        va = mk(7, 8, 9, 1'b0);
        vb = mk(-5, -6, -7, 1'b1);
        vn = mk(-2048, 2047, 55, 1'b0);
        vecs[0] = '{5, 6, 7, v5, v6, v7};
        vecs[1] = '{6, 5, 6, v6, v5, v6};
        vecs[2] = '{7, 7, 5, v7, v7, v5};
        vecs[3] = '{0, 1, 2, z, z, z};
        vecs[4] = '{3, 4, 5, z, z, z};
        vecs[5] = '{6, 7, 7, z, z, z};

        rstn = 1'b0;
        vif.i_clear = 1'b0; vif.i_write_en = 1'b0; vif.i_write_addr = '0;
        vif.i_write_data = '0; vif.i_write_invalid = 1'b0;
        vif.i_read_en = 1'b0; vif.i_vertex_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_dv", 64'(vif.o_dv), 64'd0);
        chk("reset_clear_done", 64'(vif.o_clear_done), 64'd0);
        chk("reset_v0", 64'({vif.o_v0_invalid, vif.o_v0}), 64'd0);
        chk("reset_v2", 64'({vif.o_v2_invalid, vif.o_v2}), 64'd0);
        rstn = 1'b1;
        #1;
        chk("reset_ready", 64'(vif.o_ready), 64'd1);
        chk("reset_write_ready", 64'(vif.o_write_ready), 64'd1);

        wr(5, v5);
        wr(6, v6);
        wr(7, v7);
        wr(4, v6);
        for (int i = 0; i < 3; i++) run_vec(i);

        // Outputs must hold the (7,7,5) response through idle time.
        bad = 0;
        dv_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (vif.o_dv) dv_cnt++;
            if ({vif.o_v0_invalid, vif.o_v0} !== v7 || {vif.o_v1_invalid, vif.o_v1} !== v7 ||
                {vif.o_v2_invalid, vif.o_v2} !== v5) bad++;
        end
        chk("idle_dv", 64'(dv_cnt), 64'd0);
        chk("idle_hold", 64'(bad), 64'd0);

        // Read and write in the same IDLE cycle: write waits for the o_dv cycle.
        @(negedge clk);
        vif.i_read_en = 1'b1; vif.i_vertex_addr = {3'd5, 3'd5, 3'd5};
        vif.i_write_en = 1'b1; vif.i_write_addr = 3'd4;
        vif.i_write_data = vn[35:0]; vif.i_write_invalid = vn[36];
        #1;
        chk("collide_write_ready", 64'(vif.o_write_ready), 64'd0);
        chk("collide_ready", 64'(vif.o_ready), 64'd1);
        @(posedge clk);
        dv_cnt = 0; dv_k = -1; wr_k = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vif.i_read_en = 1'b0;
            #1;
            if (vif.o_dv) begin dv_cnt++; dv_k = k; end
            if (vif.o_write_ready && vif.i_write_en) begin
                wr_k = k;
                @(posedge clk);
                #1 vif.i_write_en = 1'b0;
            end
        end
        chk("collide_dv_k", 64'(dv_k), 64'd4);
        chk("collide_wr_k", 64'(wr_k), 64'd4);
        do_read(4, 5, 4, -1, dv_cnt, dv_k, r0, r1, r2);
        chk("newdata_v0", 64'(r0), 64'(vn));
        chk("newdata_v1", 64'(r1), 64'(v5));
        chk("newdata_v2", 64'(r2), 64'(vn));

        // Second request during RD1 must be ignored.
        do_read(5, 6, 7, 1, dv_cnt, dv_k, r0, r1, r2);
        chk("reread_dv_count", 64'(dv_cnt), 64'd1);
        chk("reread_dv_k", 64'(dv_k), 64'd4);
        chk("reread_v0", 64'(r0), 64'(v5));
        chk("reread_v2", 64'(r2), 64'(v7));

        // Clear sweep with a write, a read and a repeat clear thrown at it.
        @(negedge clk);
        vif.i_clear = 1'b1;
        @(posedge clk);
        low_cnt = 0; done_cnt = 0; done_k = -1; dv_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!vif.o_ready) low_cnt++;
            if (vif.o_clear_done) begin done_cnt++; done_k = k; end
            if (vif.o_dv) dv_cnt++;
            vif.i_clear = (k == 2);
            if (k == 0) begin
                vif.i_write_en = 1'b1; vif.i_write_addr = 3'd5;
                vif.i_write_data = va[35:0]; vif.i_write_invalid = 1'b0;
                vif.i_read_en = 1'b1; vif.i_vertex_addr = {3'd5, 3'd5, 3'd5};
            end
            if (k == 3) begin
                vif.i_write_en = 1'b0;
                vif.i_read_en  = 1'b0;
            end
        end
        chk("clear_busy_cycles", 64'(low_cnt), 64'd8);
        chk("clear_done_count", 64'(done_cnt), 64'd1);
        chk("clear_done_k", 64'(done_k), 64'd8);
        chk("clear_no_dv", 64'(dv_cnt), 64'd0);
        for (int i = 3; i < 6; i++) run_vec(i);

        // Reset asserted during a read.
        wr(2, va);
        wr(3, vb);
        do_read(3, 2, 3, -1, dv_cnt, dv_k, r0, r1, r2);
        chk("prereset_v0", 64'(r0), 64'(vb));
        chk("prereset_v1", 64'(r1), 64'(va));
        @(negedge clk);
        vif.i_read_en = 1'b1; vif.i_vertex_addr = {3'd2, 3'd3, 3'd2};
        @(posedge clk);
        #1 vif.i_read_en = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midreset_v0", 64'({vif.o_v0_invalid, vif.o_v0}), 64'd0);
        chk("midreset_v1", 64'({vif.o_v1_invalid, vif.o_v1}), 64'd0);
        chk("midreset_ready", 64'(vif.o_ready), 64'd1);
        dv_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (vif.o_dv) dv_cnt++;
        end
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (vif.o_dv) dv_cnt++;
        end
        chk("midreset_no_dv", 64'(dv_cnt), 64'd0);
        do_read(2, 3, 2, -1, dv_cnt, dv_k, r0, r1, r2);
        chk("postreset_dv_k", 64'(dv_k), 64'd4);
        chk("postreset_v0", 64'(r0), 64'(va));
        chk("postreset_v1", 64'(r1), 64'(vb));
        chk("postreset_v2", 64'(r2), 64'(va));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/transformed_vertex_buffer.md
Name: transformed_vertex_buffer

Overview:
Responder side of the vertex-fetch interface used by the primitive assembler. It stores clip/screen-space vertices written by the vertex transform stage, each with a per-vertex invalid flag. It answers a three-address read request with three vertices and a single data-valid pulse. Storage is one single-port synchronous-read RAM, so the three reads are serialised and arbitrated against writes and a clear sweep.

Parameters:
DATAWIDTH, 12, signed width of each vertex component.
MAX_VERTEX_COUNT, 16384, RAM depth; address width AW = $clog2(MAX_VERTEX_COUNT).

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
i_clear  in  1  start a clear sweep that marks every entry invalid
i_write_en  in  1  write request, vertex port
i_write_addr  in  AW  write address
i_write_data  in  3 x DATAWIDTH signed  vertex x, y, z
i_write_invalid  in  1  invalid flag stored with the vertex
o_write_ready  out  1  write accepted this cycle if i_write_en is also high
i_read_en  in  1  read request pulse, from the assembler
i_vertex_addr  in  3 x AW  three vertex addresses, sampled with i_read_en
o_ready  out  1  high in IDLE; a read or clear can be accepted
o_v0, o_v1, o_v2  out  3 x DATAWIDTH signed each  returned vertices
o_v0_invalid, o_v1_invalid, o_v2_invalid  out  1 each  returned invalid flags
o_dv  out  1  one-cycle pulse; the response is valid
o_clear_done  out  1  one-cycle pulse at the end of a sweep

Behaviour:
- RAM word = {invalid, z, y, x}, 3*DATAWIDTH+1 bits. One access (read or write) per cycle. Synchronous read: data is available one cycle after the address.
- Reset behaviour:
  - State goes to IDLE. All o_v*, o_v*_invalid, o_dv and o_clear_done go to 0.
  - Latched addresses and the clear counter go to 0.
  - RAM contents are not reset.
- States: IDLE, RD0, RD1, RD2, RDWAIT, CLEAR.
- o_ready = (state == IDLE).
- o_write_ready = (state == IDLE) & ~i_read_en & ~i_clear. This is combinational.
- IDLE priority, highest first:
  - i_clear: go to CLEAR, counter = 0.
  - i_read_en: latch the three addresses, go to RD0.
  - i_write_en: perform the write this cycle.
  - A write that is not accepted is dropped; the writer must hold i_write_en until o_write_ready is high.
- Read sequence, with the request sampled at edge N:
  - RD0 presents a0 at edge N+1.
  - RD1 presents a1 and captures lane 0 at edge N+2.
  - RD2 presents a2 and captures lane 1 at edge N+3.
  - RDWAIT captures lane 2, sets o_dv=1 and returns to IDLE at edge N+4.
  - o_dv is high for exactly one cycle, between edges N+4 and N+5.
  - Fixed latency of 4 cycles. No back-to-back overlap; the next request is accepted from the cycle o_dv is high.
- o_v*/o_v*_invalid hold their last response until the next capture. They are never cleared by o_dv falling.
- i_read_en outside IDLE is ignored: no response and no error flag. The assembler issues only one request per o_dv.
- Duplicate addresses (a0==a1, etc.) are legal and return identical data on those lanes.
- CLEAR sweep:
  - Writes {invalid=1, data=0} to address counter, one per cycle, for MAX_VERTEX_COUNT cycles.
  - On the last address it pulses o_clear_done and returns to IDLE.
  - Reads, writes and a further i_clear during CLEAR are ignored.
- Reset mid-read: the response is aborted and no o_dv is produced.
- Reset mid-clear: the sweep is aborted and the RAM is partially cleared. Software must reissue i_clear.
- Address arithmetic: the clear counter is AW+1 bits wide. Termination is on counter == MAX_VERTEX_COUNT-1, so non-power-of-two depths are handled.

Test Plan:
- Write addr 5 = (10,-20,30, inv=0), addr 6 = (-1,2,-3, inv=1), addr 7 = (100,0,-100, inv=0). Read (5,6,7) at edge N -> o_dv only in cycle N+4; o_v0=(10,-20,30), o_v1=(-1,2,-3) with o_v1_invalid=1, o_v2=(100,0,-100).
- Read (7,7,5) -> o_v0 = o_v1 = (100,0,-100), o_v2=(10,-20,30); then 20 idle cycles -> outputs unchanged, o_dv stays 0.
- i_read_en and i_write_en in the same IDLE cycle -> o_write_ready=0, no write. Hold i_write_en -> write lands after o_dv. A subsequent read returns the new data.
- i_read_en pulsed again during RD1 -> ignored; exactly one o_dv.
- MAX_VERTEX_COUNT=8, i_clear -> o_ready=0 for 8 cycles, one o_clear_done pulse. Every read then returns invalid=1 with data 0. Writes during the sweep are dropped.
- Assert rstn=0 asynchronously at N+2 of a read -> o_dv never pulses and outputs are 0. After release a new read completes with 4-cycle latency and the data written before reset.
